// File: rtl/traffic_phase_controller.sv
// Demand-actuated round-robin intersection controller for NUM_PHASES conflicting approaches.
// Optional flash mode is compiled in with `define FLASH_EN.
module traffic_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 16,
  parameter int GREEN_MAX  = 48,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 2
`ifdef FLASH_EN
  , parameter int FLASH_DIV = 8
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef FLASH_EN
  input  logic                            flash,
`endif
  input  logic [NUM_PHASES-1:0]           v_detect,
  output logic [3*NUM_PHASES-1:0]         lights,
  output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
  output logic                            phase_change
);

  localparam int PH_W = $clog2(NUM_PHASES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
`ifdef FLASH_EN
  localparam logic [CNT_W-1:0] FL_LAST   = CNT_W'(FLASH_DIV - 1);
`endif

  // S_FLASH doubles as the "dark" lamp pattern for the flash blink.
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

  state_t                state;
  logic [CNT_W-1:0]      counter;
  logic [NUM_PHASES-1:0] req;
  logic [NUM_PHASES-1:0] act_mask;
  logic [NUM_PHASES-1:0] req_eff;
  logic [PH_W-1:0]       next_phase;
  logic [PH_W-1:0]       green_phase;
  logic                  other_req;
  logic                  gap_out;
  logic                  max_out;
`ifdef FLASH_EN
  logic [1:0]            flash_sync;
  logic                  flash_dark;
  logic                  from_flash;
`endif

  function automatic logic [3*NUM_PHASES-1:0] lamp_word(input state_t mode,
                                                        input logic [PH_W-1:0] ph);
    logic [3*NUM_PHASES-1:0] w;
    w = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (PH_W'(p) == ph && mode == S_GREEN)       w[3*p +: 3] = 3'b001;
      else if (PH_W'(p) == ph && mode == S_YELLOW) w[3*p +: 3] = 3'b010;
      else if (mode == S_FLASH)                    w[3*p +: 3] = 3'b000;
      else                                         w[3*p +: 3] = 3'b100;
    end
    return w;
  endfunction

  always_comb begin
    act_mask = '0;
    act_mask[active_phase] = 1'b1;
    other_req = |(req & ~act_mask);
    gap_out   = (counter >= GMIN_LAST) && !v_detect[active_phase];
    max_out   = (counter >= GMAX_LAST);
    // Clearance-time detects count too, so fold in the live inputs.
    req_eff    = req | v_detect;
    next_phase = active_phase;
    for (int i = NUM_PHASES; i >= 1; i--) begin
      if (req_eff[(int'(active_phase) + i) % NUM_PHASES])
        next_phase = PH_W'((int'(active_phase) + i) % NUM_PHASES);
    end
`ifdef FLASH_EN
    green_phase = from_flash ? '0 : next_phase;
`else
    green_phase = next_phase;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_GREEN;
      active_phase <= '0;
      lights       <= lamp_word(S_GREEN, '0);
      counter      <= '0;
      req          <= '0;
      phase_change <= 1'b0;
`ifdef FLASH_EN
      flash_sync   <= 2'b00;
      flash_dark   <= 1'b0;
      from_flash   <= 1'b0;
`endif
    end else begin
      phase_change <= 1'b0;
      counter      <= (counter == CNT_MAX) ? counter : counter + 1'b1;
      for (int p = 0; p < NUM_PHASES; p++) begin
        if (v_detect[p] && !(state == S_GREEN && PH_W'(p) == active_phase))
          req[p] <= 1'b1;
      end
`ifdef FLASH_EN
      flash_sync <= {flash_sync[0], flash};
      if (flash_sync[1]) begin
        req <= '0;
        if (state != S_FLASH) begin
          state      <= S_FLASH;
          counter    <= '0;
          flash_dark <= 1'b0;
          lights     <= lamp_word(S_ALLRED, active_phase);
        end else if (counter == FL_LAST) begin
          counter    <= '0;
          flash_dark <= ~flash_dark;
          lights     <= lamp_word(flash_dark ? S_ALLRED : S_FLASH, active_phase);
        end
      end else
`endif
      begin
        case (state)
          S_GREEN: begin
            if (other_req && (gap_out || max_out)) begin
              state   <= S_YELLOW;
              counter <= '0;
              lights  <= lamp_word(S_YELLOW, active_phase);
            end
          end
          S_YELLOW: begin
            if (counter == Y_LAST) begin
              state   <= S_ALLRED;
              counter <= '0;
              lights  <= lamp_word(S_ALLRED, active_phase);
            end
          end
          S_ALLRED: begin
            if (counter == AR_LAST) begin
              state             <= S_GREEN;
              counter           <= '0;
              active_phase      <= green_phase;
              lights            <= lamp_word(S_GREEN, green_phase);
              phase_change      <= 1'b1;
              req[green_phase]  <= 1'b0;
`ifdef FLASH_EN
              from_flash        <= 1'b0;
`endif
            end
          end
`ifdef FLASH_EN
          S_FLASH: begin
            state      <= S_ALLRED;
            counter    <= '0;
            from_flash <= 1'b1;
            lights     <= lamp_word(S_ALLRED, active_phase);
          end
`endif
          default: begin
            state   <= S_ALLRED;
            counter <= '0;
            lights  <= lamp_word(S_ALLRED, active_phase);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: a cycle model pushes expected outputs,
// which are popped and compared against the DUT one clock later.
module tb_traffic_phase_controller;
  localparam int N    = 4;
  localparam int GMIN = 16;
  localparam int GMAX = 48;
  localparam int YT   = 2;
  localparam int AT   = 2;
  localparam logic [11:0] RESET_LIGHTS = 12'b100_100_100_001;
  localparam logic [11:0] ALL_RED      = 12'b100_100_100_100;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v_detect;
  logic [11:0] lights;
  logic [1:0]  active_phase;
  logic        phase_change;
`ifdef FLASH_EN
  logic        flash;
`endif

  always #5 clk = ~clk;

  traffic_phase_controller dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FLASH_EN
    .flash        (flash),
`endif
    .v_detect     (v_detect),
    .lights       (lights),
    .active_phase (active_phase),
    .phase_change (phase_change)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0=green, 1=yellow, 2=all-red; mel = cycles elapsed in the state.
  int         ms, mact, mel;
  logic [3:0] mreq;
  logic       mpc;

  typedef struct packed {
    logic [11:0] l;
    logic [1:0]  a;
    logic        pc;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [11:0] lamps(input int st, input int ph);
    logic [11:0] w;
    for (int p = 0; p < N; p++) begin
      if (p == ph && st == 0)      w[3*p +: 3] = 3'b001;
      else if (p == ph && st == 1) w[3*p +: 3] = 3'b010;
      else                         w[3*p +: 3] = 3'b100;
    end
    return w;
  endfunction

  function automatic logic lamps_legal(input logic [11:0] w);
    int nonred;
    logic ok;
    nonred = 0;
    ok = 1'b1;
    for (int p = 0; p < N; p++) begin
      if (w[3*p +: 3] != 3'b100 && w[3*p +: 3] != 3'b010 && w[3*p +: 3] != 3'b001) ok = 1'b0;
      if (w[3*p +: 3] != 3'b100) nonred++;
    end
    return ok && (nonred <= 1);
  endfunction

  task automatic model_reset();
    ms = 0; mact = 0; mel = 0; mreq = 4'b0; mpc = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] v);
    int ns, na, nel, idx;
    logic [3:0] nr;
    logic other, found;
    ns = ms; na = mact; nr = mreq; mpc = 1'b0;
    nel = (mel < 255) ? mel + 1 : 255;
    other = 1'b0;
    for (int p = 0; p < N; p++) if (p != mact && mreq[p]) other = 1'b1;
    if (ms == 0) begin
      if (other && ((mel >= GMIN - 1 && !v[mact]) || mel >= GMAX - 1)) begin ns = 1; nel = 0; end
    end else if (ms == 1) begin
      if (mel == YT - 1) begin ns = 2; nel = 0; end
    end else begin
      if (mel == AT - 1) begin
        ns = 0; nel = 0; mpc = 1'b1; found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (mact + k) % N;
          if (!found && (mreq[idx] || v[idx])) begin na = idx; found = 1'b1; end
        end
      end
    end
    for (int p = 0; p < N; p++) if (v[p] && !(ms == 0 && p == mact)) nr[p] = 1'b1;
    if (mpc) nr[na] = 1'b0;
    ms = ns; mact = na; mel = nel; mreq = nr;
  endtask

  task automatic cycle(input logic [3:0] v);
    exp_t e;
    v_detect = v;
    model_step(v);
    sbq.push_back({lamps(ms, mact), 2'(mact), mpc});
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    check("sb_outputs", {19'b0, lights, active_phase, phase_change}, {19'b0, e});
    check("lamp_invariant", 32'(lamps_legal(lights)), 32'd1);
  endtask

  task automatic run_until_change(input string tag, input int budget, input int exp_phase);
    int n;
    n = 0;
    do begin
      cycle(4'b0000);
      n++;
    end while (!phase_change && n < budget);
    check({tag, "_reached"}, 32'(phase_change), 32'd1);
    check({tag, "_phase"}, 32'(active_phase), 32'(exp_phase));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    v_detect = 4'b0;
`ifdef FLASH_EN
    flash = 1'b0;
`endif
    model_reset();
    #1;
    check("reset_lights", 32'(lights), 32'(RESET_LIGHTS));
    check("reset_phase", 32'(active_phase), 32'd0);
    check("reset_pulse", 32'(phase_change), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Gap-out: single detect on phase 2 at cycle 5 while phase 0 is idle.
    for (int i = 0; i < 20; i++) begin
      cycle(i == 5 ? 4'b0100 : 4'b0000);
      if (i == 14) check("t3_still_green", 32'(lights[2:0]), 32'b001);
      if (i == 15) check("t3_yellow_c16", 32'(lights[2:0]), 32'b010);
      if (i == 17) check("t3_allred_c18", 32'(lights), 32'(ALL_RED));
      if (i == 19) begin
        check("t3_phase2_c20", 32'(active_phase), 32'd2);
        check("t3_pulse_c20", 32'(phase_change), 32'd1);
        check("t3_lights_c20", 32'(lights), 32'(12'b100_001_100_100));
      end
    end

    // Max-out: phase 2 demand held with phase 3 waiting.
    for (int k = 0; k < 48; k++) begin
      cycle(4'b1100);
      if (k == 46) check("t4_green_47", 32'(lights[8:6]), 32'b001);
      if (k == 47) check("t4_yellow_48", 32'(lights[8:6]), 32'b010);
    end
    repeat (4) cycle(4'b0000);
    check("t4_phase3", 32'(active_phase), 32'd3);
    check("t4_pulse", 32'(phase_change), 32'd1);

    // Round-robin: reach phase 1, then request 0 and 3 together.
    cycle(4'b0010);
    run_until_change("t5_to1", 40, 1);
    cycle(4'b1001);
    run_until_change("t5_to3", 40, 3);
    run_until_change("t5_to0", 40, 0);

    // Rest in green with no demand; counter must saturate.
    repeat (300) cycle(4'b0000);
    check("t2_phase", 32'(active_phase), 32'd0);
    check("t2_counter_sat", 32'(dut.counter), 32'd255);
    cycle(4'b0010);
    run_until_change("t2_after_sat", 40, 1);

    // Sparse random demand.
    for (int i = 0; i < 500; i++) begin
      cycle({4{1'b0}} | {($urandom_range(7) == 0), ($urandom_range(7) == 0),
                         ($urandom_range(7) == 0), ($urandom_range(7) == 0)});
    end

    // Reset asserted mid-yellow.
    cycle(4'b1111);
    n = 0;
    while (ms != 1 && n < 100) begin cycle(4'b0000); n++; end
    check("t1_reached_yellow", 32'(ms), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_lights", 32'(lights), 32'(RESET_LIGHTS));
    check("t1_async_phase", 32'(active_phase), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0000);
      if (i == 0) check("t1_no_pulse", 32'(phase_change), 32'd0);
    end
    check("t1_demand_lost", 32'(lights), 32'(RESET_LIGHTS));

`ifdef FLASH_EN
    flash = 1'b1;
    n = 0;
    while (lights != ALL_RED && n < 10) begin @(negedge clk); n++; end
    check("t6_flash_red", 32'(lights), 32'(ALL_RED));
    n = 0;
    while (lights == ALL_RED && n < 20) begin @(negedge clk); n++; end
    check("t6_red_len", 32'(n), 32'd8);
    check("t6_dark", 32'(lights), 32'd0);
    n = 0;
    while (lights == 12'd0 && n < 20) begin @(negedge clk); n++; end
    check("t6_dark_len", 32'(n), 32'd8);
    flash = 1'b0;
    n = 0;
    while (!phase_change && n < 40) begin @(negedge clk); n++; end
    check("t6_release_pulse", 32'(phase_change), 32'd1);
    check("t6_release_lights", 32'(lights), 32'(RESET_LIGHTS));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end
endmodule
